conv2d_stream: RTL and testbench
================================

// Module: conv2d_stream
// PURPOSE
//  Streaming KxK 2-D convolution engine; parametrised successor of the 1x1 convolve path in user_proj_conv.
//  Loads a signed KxK kernel, accepts a raster-order unsigned pixel stream with valid/ready handshakes,
//  keeps K-1 line buffers, emits one saturated signed pixel per full ("valid"-mode) window with backpressure.
// PARAMETERS
//  BITS        9    pixel and coefficient width
//  KERNEL_SIZE 3    kernel edge K (>=2)
//  IMG_WIDTH   16   pixels per row W (>=K)
//  IMG_HEIGHT  16   rows per frame H (>=K)
//  ACC_BITS    2*BITS+1+$clog2(K*K)   signed accumulator width (derived, do not override)
// PORTS
//  clk            in   1     single clock, rising edge
//  reset          in   1     asynchronous active-high reset
//  kernel_valid   in   1     coefficient present on kernel_in
//  kernel_in      in   BITS  signed coefficient, row-major k(0,0)..k(K-1,K-1)
//  kernel_ready   out  1     high in state K_LOAD
//  kernel_reload  in   1     request new kernel; honoured only between frames
//  pix_valid      in   1     pixel present on pix_in
//  pix_in         in   BITS  unsigned pixel, raster order
//  pix_ready      out  1     pixel accepted when pix_valid & pix_ready
//  out_valid      out  1     out_pixel valid
//  out_pixel      out  BITS  signed saturated result
//  out_last       out  1     marks last output of the frame
//  out_ready      in   1     downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=K_LOAD, all outputs 0 except kernel_ready=1 (K_LOAD),
//   kernel regs, line buffers, window, pipeline regs, row/col counters cleared; no partial frame survives.
//  States: K_LOAD -> STREAM after K*K-th coefficient handshake; STREAM -> K_LOAD when kernel_reload=1
//   and row=col=0 (frame boundary, pipeline empty); kernel_reload at any other time ignored.
//  K_LOAD: coefficient i stored at index i per kernel_valid&kernel_ready; pix_ready=0.
//  STREAM: adv = !out_valid | out_ready; pix_ready = adv. Whole pipeline stalls when adv=0; no data lost.
//  Accepted pixel (row r, col c) enters line buffers/window; col wraps at W-1 -> 0, row++; row wraps at H-1
//   -> 0 (next frame, kernel retained). Window valid when r>=K-1 and c>=K-1.
//  Convolution (flipped kernel): y = sum k(i,j)*x(R-i,C-j), (R,C)=current pixel, i.e. k(0,0) weights newest.
//  Pipeline: S1 registers K*K signed products (pixel zero-extended to BITS+1); S2 registers adder-tree sum,
//   saturates, drives out_valid. Latency 2 accepted-cycles from window-completing pixel to out_valid.
//  Saturation: sum > 2^(BITS-1)-1 -> 2^(BITS-1)-1; sum < -2^(BITS-1) -> -2^(BITS-1); else truncate.
//  out_last=1 with output for r=H-1, c=W-1. Output count per frame (W-K+1)*(H-K+1).
//  out_pixel/out_last hold stable while out_valid & !out_ready.
// CONFIGURATION
//  CONV_RELU_EN defined: after saturation, negative results forced to 0 (range 0..2^(BITS-1)-1).
//  CONV_RELU_EN undefined: full signed saturated range output. No other behaviour differs.
// STRUCTURE
//  conv_pkg: state encoding (K_LOAD, STREAM), ACC_BITS function, saturation-limit constants.
//  Sub-module conv_line_buffer: W-deep BITS-wide delay line with enable (instantiated K-1 times).
//  Top holds FSM, counters, kernel regs, window regs, multiply and sum/saturate stages.
// TESTING (K=3, W=H=5, BITS=9, pixel x(r,c)=5r+c)
//  Kernel k(1,1)=1 else 0, one frame -> 6,7,8,11,12,13,16,17,18; out_last only on 18.
//  Kernel k(0,0)=1 else 0 (flip check) -> 12,13,14,17,18,19,22,23,24.
//  All coef 255, all pixels 511 -> every output 255; all coef -256 -> -256 (0 with CONV_RELU_EN).
//  out_ready low 10 cycles mid-frame -> pix_ready low, out_pixel held, sequence identical to unstalled run.
//  Async reset asserted mid-frame -> outputs 0 same cycle, kernel_ready=1; reload kernel, frame runs clean.
//  Two back-to-back frames, kernel_reload pulsed mid-frame 1 -> ignored, both frames identical; pulsed at
//   frame boundary -> kernel_ready=1, pix_ready=0 until 9 coefficients loaded.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: FSM encoding plus accumulator sizing and saturation limits for conv2d_stream.
package conv_pkg;
  typedef enum logic {K_LOAD, STREAM} state_t;
  function automatic int acc_bits(input int bits, input int k);
    return 2 * bits + 1 + $clog2(k * k);
  endfunction
  function automatic int sat_hi(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction
  function automatic int sat_lo(input int bits);
    return -(1 << (bits - 1));
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-deep shift-register delay line that advances only when en_i is high.
module conv_line_buffer #(
  parameter int BITS  = 9,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [BITS-1:0] din_i,
  output logic [BITS-1:0] dout_o
);
  logic [BITS-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  assign dout_o = mem_q[DEPTH-1];
endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK valid-mode 2-D convolution with handshaked kernel load, pixel input and output.
// Define CONV_RELU_EN to force negative saturated results to zero.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kernel_valid,
  input  logic [BITS-1:0] kernel_in,
  output logic            kernel_ready,
  input  logic            kernel_reload,
  input  logic            pix_valid,
  input  logic [BITS-1:0] pix_in,
  output logic            pix_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_pixel,
  output logic            out_last,
  input  logic            out_ready
);
  localparam int K        = KERNEL_SIZE;
  localparam int N        = K * K;
  localparam int ACC_BITS = acc_bits(BITS, K);
  localparam int PB       = 2 * BITS + 1;
  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int IW       = $clog2(N);
  localparam logic signed [ACC_BITS-1:0] SAT_HI = ACC_BITS'(sat_hi(BITS));
  localparam logic signed [ACC_BITS-1:0] SAT_LO = ACC_BITS'(sat_lo(BITS));

  state_t state_q, state_d;
  logic [IW-1:0] kidx_q;
  logic signed [BITS-1:0] coef_q [N];
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [BITS-1:0] col0 [K];
  logic [BITS-1:0] win_q [K][1:K-1];
  logic [BITS-1:0] tap [N];
  logic signed [PB-1:0] prod_q [N];
  logic v1_q, last1_q, out_valid_q, out_last_q;
  logic [BITS-1:0] out_pixel_q, sat, res;
  logic signed [ACC_BITS-1:0] sum;
  logic adv, kacc, acc, reload_go, col_end, row_end, win_ok;

  assign adv          = !out_valid_q || out_ready;
  assign kernel_ready = state_q == K_LOAD;
  assign kacc         = kernel_valid && kernel_ready;
  assign reload_go    = state_q == STREAM && kernel_reload && row_q == '0 && col_q == '0;
  assign pix_ready    = state_q == STREAM && adv && !reload_go;
  assign acc          = pix_valid && pix_ready;
  assign col_end      = col_q == CW'(IMG_WIDTH - 1);
  assign row_end      = row_q == RW'(IMG_HEIGHT - 1);
  assign win_ok       = row_q >= RW'(K - 1) && col_q >= CW'(K - 1);
  assign out_valid    = out_valid_q;
  assign out_pixel    = out_pixel_q;
  assign out_last     = out_last_q;

  always_comb begin
    state_d = state_q;
    if (kacc && kidx_q == IW'(N - 1)) state_d = STREAM;
    if (reload_go) state_d = K_LOAD;
  end

  // col0[i] is x(r-i, c): the incoming pixel followed by each line buffer's output
  assign col0[0] = pix_in;
  for (genvar i = 1; i < K; i++) begin : g_lb
    conv_line_buffer #(.BITS(BITS), .DEPTH(IMG_WIDTH)) u_lb (
      .clk, .rst(reset), .en_i(acc), .din_i(col0[i-1]), .dout_o(col0[i])
    );
  end

  for (genvar i = 0; i < K; i++) begin : g_row
    assign tap[i*K] = col0[i];
    for (genvar j = 1; j < K; j++) begin : g_col
      assign tap[i*K+j] = win_q[i][j];
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= K_LOAD;
      kidx_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      for (int n = 0; n < N; n++) coef_q[n] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 1; j < K; j++) win_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      if (kacc) begin
        coef_q[kidx_q] <= kernel_in;
        kidx_q <= kidx_q == IW'(N - 1) ? '0 : kidx_q + IW'(1);
      end
      if (acc) begin
        col_q <= col_end ? '0 : col_q + CW'(1);
        if (col_end) row_q <= row_end ? '0 : row_q + RW'(1);
        for (int i = 0; i < K; i++)
          for (int j = 1; j < K; j++) win_q[i][j] <= tap[i*K+j-1];
      end
    end

  always_comb begin
    sum = '0;
    for (int n = 0; n < N; n++) sum = sum + ACC_BITS'(prod_q[n]);
    sat = sum > SAT_HI ? SAT_HI[BITS-1:0] : sum < SAT_LO ? SAT_LO[BITS-1:0] : sum[BITS-1:0];
`ifdef CONV_RELU_EN
    res = sat[BITS-1] ? '0 : sat;
`else
    res = sat;
`endif
  end

  // Both stages move together on adv, so a blocked output freezes the whole pipe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
      for (int n = 0; n < N; n++) prod_q[n] <= '0;
    end else if (adv) begin
      v1_q        <= acc && win_ok;
      last1_q     <= acc && row_end && col_end;
      for (int n = 0; n < N; n++) prod_q[n] <= PB'(coef_q[n]) * PB'($signed({1'b0, tap[n]}));
      out_valid_q <= v1_q;
      out_last_q  <= last1_q;
      out_pixel_q <= res;
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: scoreboard bench for conv2d_stream at K=3, W=H=5, BITS=9 with pixel x(r,c)=5r+c.
module tb_conv2d_stream;
  localparam int K = 3, W = 5, H = 5, B = 9;
  logic clk = 1'b0, reset = 1'b1;
  logic kernel_valid = 1'b0, kernel_reload = 1'b0, pix_valid = 1'b0, out_ready = 1'b1;
  logic [B-1:0] kernel_in = '0, pix_in = '0;
  logic kernel_ready, pix_ready, out_valid, out_last;
  logic [B-1:0] out_pixel;
  typedef struct {int v; int last;} exp_t;
  exp_t sb[$];
  int kern[9];
  int pix_mode = 0;
  int checks = 0, errors = 0;
  logic held = 1'b0;
  int held_v, held_l;

  conv2d_stream #(.BITS(B), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .kernel_valid(kernel_valid), .kernel_in(kernel_in),
    .kernel_ready(kernel_ready), .kernel_reload(kernel_reload), .pix_valid(pix_valid),
    .pix_in(pix_in), .pix_ready(pix_ready), .out_valid(out_valid), .out_pixel(out_pixel),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pixval(input int r, input int c);
    return pix_mode != 0 ? 511 : 5 * r + c;
  endfunction

  function automatic int expv(input int r, input int c);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) s += kern[i*K+j] * pixval(r - i, c - j);
    if (s > 255) s = 255;
    if (s < -256) s = -256;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic load_kernel();
    int t;
    for (int i = 0; i < 9; i++) begin
      t = 0;
      kernel_valid = 1'b1;
      kernel_in = B'(kern[i]);
      @(negedge clk);
      while (!kernel_ready && t < 50) begin @(negedge clk); t++; end
      check("load_kernel_ready", kernel_ready, 1);
      check("load_pix_ready", pix_ready, 0);
      @(posedge clk); #1;
    end
    kernel_valid = 1'b0;
  endtask

  task automatic send_pix(input int r, input int c);
    int t = 0;
    pix_valid = 1'b1;
    pix_in = B'(pixval(r, c));
    @(negedge clk);
    while (!pix_ready && t < 200) begin @(negedge clk); t++; end
    if (!pix_ready) check("pix_accept_timeout", pix_ready, 1);
    if (r >= K - 1 && c >= K - 1) sb.push_back('{expv(r, c), (r == H - 1 && c == W - 1) ? 1 : 0});
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int n = 0; n < W * H; n++) send_pix(n / W, n % W);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic reload();
    kernel_reload = 1'b1;
    @(posedge clk); #1;
    kernel_reload = 1'b0;
    check("reload_kernel_ready", kernel_ready, 1);
    check("reload_pix_ready", pix_ready, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) held = 1'b0;
    else begin
      if (held && out_valid) begin
        check("hold_pixel", $signed(out_pixel), held_v);
        check("hold_last", out_last, held_l);
      end
      if (out_valid && !out_ready) check("stall_pix_ready", pix_ready, 0);
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_pixel", $signed(out_pixel), e.v);
          check("out_last", out_last, e.last);
        end
      end
      held = out_valid && !out_ready;
      held_v = $signed(out_pixel);
      held_l = out_last;
    end
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    check("rst_kernel_ready", kernel_ready, 1);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_last", out_last, 0);
    reset = 1'b0;
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel(); send_frame(); drain();
    reload(); kern = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    load_kernel(); send_frame(); drain();
    reload(); pix_mode = 1; kern = '{default: 255};
    load_kernel(); send_frame(); drain();
    reload(); kern = '{default: -256};
    load_kernel(); send_frame(); drain();
    reload(); pix_mode = 0; kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    fork
      send_frame();
      begin
        repeat (15) @(posedge clk); #1 out_ready = 1'b0;
        repeat (10) @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    for (int n = 0; n < 14; n++) send_pix(n / W, n % W);
    out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("pre_reset_out_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_pixel", out_pixel, 0);
    check("async_out_last", out_last, 0);
    check("async_kernel_ready", kernel_ready, 1);
    check("async_pix_ready", pix_ready, 0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    load_kernel(); send_frame(); drain();
    fork
      begin send_frame(); send_frame(); end
      begin
        repeat (8) @(posedge clk); #1 kernel_reload = 1'b1;
        @(posedge clk); #1 kernel_reload = 1'b0;
        check("reload_ignored", kernel_ready, 0);
      end
    join
    drain();
    reload(); kern = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    load_kernel(); send_frame(); drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
